// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and geometry helpers for the data cache controller
package dcache_pkg;

    localparam int WORD_W             = 32;
    localparam int DEFAULT_LINES      = 32;
    localparam int DEFAULT_LINE_WORDS = 4;
    localparam int LINE_W             = WORD_W * DEFAULT_LINE_WORDS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    // Byte-offset bits covering one line (word select plus the two byte bits).
    function automatic int off_bits(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int lines, input int line_words);
        return 32 - off_bits(line_words) - idx_bits(lines);
    endfunction

    function automatic int line_width(input int line_words);
        return WORD_W * line_words;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag, data, valid and dirty storage for the direct-mapped cache
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES      = DEFAULT_LINES,
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
    localparam int IDX_W     = idx_bits(LINES),
    localparam int TAG_W     = tag_bits(LINES, LINE_WORDS),
    localparam int WSEL_W    = $clog2(LINE_WORDS),
    localparam int LW        = line_width(LINE_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LW-1:0]     rd_line,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WSEL_W-1:0] wr_word,
    input  logic [31:0]       wr_data,
    input  logic              fill_en,
    input  logic [IDX_W-1:0]  fill_idx,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LW-1:0]     fill_line
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LW-1:0]    data_q [LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    // Line status: fill marks the line valid and clean, a word write marks it dirty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
            dirty_q[fill_idx] <= 1'b0;
        end else if (wr_en) begin
            dirty_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data payload are never reset; valid gates their use.
    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_line;
        end else if (wr_en) begin
            data_q[wr_idx][32*wr_word +: 32] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES      = DEFAULT_LINES,
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cpu_req_i,
    input  logic                    cpu_we_i,
    input  logic [31:0]             cpu_addr_i,
    input  logic [31:0]             cpu_wdata_i,
    output logic [31:0]             cpu_rdata_o,
    output logic                    cpu_stall_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [31:0]             mem_addr_o,
    output logic [32*LINE_WORDS-1:0] mem_wdata_o,
    input  logic [32*LINE_WORDS-1:0] mem_rdata_i,
    input  logic                    mem_ack_i
);

    localparam int OFF    = off_bits(LINE_WORDS);
    localparam int IDX_W  = idx_bits(LINES);
    localparam int TAG_W  = tag_bits(LINES, LINE_WORDS);
    localparam int WSEL_W = $clog2(LINE_WORDS);
    localparam int LW     = line_width(LINE_WORDS);

    state_t state_q, state_d;
    logic   mem_req_q, mem_we_q;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WSEL_W-1:0] req_word;
    logic              unused_addr_bits;

    logic              rd_valid, rd_dirty, hit;
    logic [TAG_W-1:0]  rd_tag;
    logic [LW-1:0]     rd_line;
    logic              wr_en, fill_en;

    assign req_word         = cpu_addr_i[OFF-1:2];
    assign req_idx          = cpu_addr_i[OFF+IDX_W-1:OFF];
    assign req_tag          = cpu_addr_i[31:OFF+IDX_W];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    dcache_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rd_idx    (req_idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .wr_en     (wr_en),
        .wr_idx    (req_idx),
        .wr_word   (req_word),
        .wr_data   (cpu_wdata_i),
        .fill_en   (fill_en),
        .fill_idx  (req_idx),
        .fill_tag  (req_tag),
        .fill_line (mem_rdata_i)
    );

    assign hit         = rd_valid & (rd_tag == req_tag);
    assign cpu_rdata_o = hit ? rd_line[32*req_word +: 32] : 32'd0;
    assign cpu_stall_o = (state_q != IDLE) | (cpu_req_i & ~hit);
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;

    // State register; memory request/direction are registered from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= (state_d != IDLE);
            mem_we_q  <= (state_d == WRITEBACK);
        end
    end

    // Next-state, array write enables and memory address/data muxing.
    always_comb begin
        state_d     = state_q;
        wr_en       = 1'b0;
        fill_en     = 1'b0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        wr_en = cpu_we_i;
                    end else if (rd_valid & rd_dirty) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                mem_addr_o  = {rd_tag, req_idx, {OFF{1'b0}}};
                mem_wdata_o = rd_line;
                if (mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_addr_o = {req_tag, req_idx, {OFF{1'b0}}};
                if (mem_ack_i) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard testbench for dcache_ctrl
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_we_i;
    logic [31:0]  cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
    logic         cpu_stall_o, mem_req_o, mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o, mem_rdata_i;
    logic         mem_ack_i;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q [$];
    logic [31:0] mem_words [logic [31:0]];
    logic [31:0] cpu_words [logic [31:0]];

    dcache_ctrl #(.LINES(32), .LINE_WORDS(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        if (a == 32'h44) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_words.exists(a)) return mem_words[a];
        return pattern(a);
    endfunction

    function automatic logic [31:0] cpu_rd(input logic [31:0] a);
        if (cpu_words.exists(a)) return cpu_words[a];
        return mem_rd(a);
    endfunction

    task automatic cpu_access(input string name, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int ack_delay, input int exp_stall,
                              input logic exp_wb, input logic [31:0] victim);
        logic [31:0]  line_a, exp_addr, exp_data;
        logic [127:0] exp_line;
        int           stalls, req_cycles;
        logic         wb_phase, done;
        line_a     = {addr[31:4], 4'h0};
        stalls     = 0;
        req_cycles = 0;
        wb_phase   = exp_wb;
        done       = 1'b0;
        @(negedge clk_i);
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        if (!we) exp_q.push_back(cpu_rd({addr[31:2], 2'b00}));
        #1;
        while (!done) begin
            if (!cpu_stall_o) begin
                if (!we) begin
                    exp_data = exp_q.pop_front();
                    tests++;
                    if (cpu_rdata_o !== exp_data) begin
                        fails++;
                        $display("FAIL %s rdata: got %h want %h", name, cpu_rdata_o, exp_data);
                    end
                end else begin
                    cpu_words[{addr[31:2], 2'b00}] = wdata;
                end
                tests++;
                if (stalls != exp_stall) begin
                    fails++;
                    $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_stall);
                end
                done = 1'b1;
            end else begin
                if (stalls == 0) begin
                    tests++;
                    if (mem_req_o !== 1'b0) begin
                        fails++;
                        $display("FAIL %s detect_cycle_req: got %b want 0", name, mem_req_o);
                    end
                end else begin
                    exp_addr = wb_phase ? victim : line_a;
                    tests++;
                    if (mem_req_o !== 1'b1 || mem_we_o !== wb_phase || mem_addr_o !== exp_addr) begin
                        fails++;
                        $display("FAIL %s mem_req: got req=%b we=%b addr=%h want req=1 we=%b addr=%h",
                                 name, mem_req_o, mem_we_o, mem_addr_o, wb_phase, exp_addr);
                    end
                    req_cycles++;
                    if (req_cycles > ack_delay) begin
                        mem_ack_i = 1'b1;
                        if (wb_phase) begin
                            for (int w = 0; w < 4; w++) exp_line[32*w +: 32] = cpu_rd(victim + 32'(4*w));
                            tests++;
                            if (mem_wdata_o !== exp_line) begin
                                fails++;
                                $display("FAIL %s wb_data: got %h want %h", name, mem_wdata_o, exp_line);
                            end
                            for (int w = 0; w < 4; w++) mem_words[victim + 32'(4*w)] = exp_line[32*w +: 32];
                        end else begin
                            for (int w = 0; w < 4; w++) mem_rdata_i[32*w +: 32] = mem_rd(line_a + 32'(4*w));
                        end
                    end
                end
                stalls++;
                if (stalls > 100) begin
                    tests++;
                    fails++;
                    $display("FAIL %s timeout: stall still high after %0d cycles", name, stalls);
                    done = 1'b1;
                end
                @(negedge clk_i);
                if (mem_ack_i) begin
                    wb_phase   = 1'b0;
                    req_cycles = 0;
                end
                mem_ack_i   = 1'b0;
                mem_rdata_i = '0;
                #1;
            end
        end
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        cpu_req_i   = 1'b0;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'd0;
        cpu_wdata_i = 32'd0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        cpu_words.delete();
        #1;
        tests++;
        if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || cpu_stall_o !== 1'b0 || mem_addr_o !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: got req=%b we=%b stall=%b addr=%h want 0 0 0 0",
                     mem_req_o, mem_we_o, cpu_stall_o, mem_addr_o);
        end
    endtask

    task automatic test_load_miss();
        cpu_access("load_miss_40", 1'b0, 32'h40, 32'd0, 0, 2, 1'b0, 32'd0);
        cpu_access("load_hit_44", 1'b0, 32'h44, 32'd0, 0, 0, 1'b0, 32'd0);
    endtask

    task automatic test_store_hit();
        cpu_access("store_hit_44", 1'b1, 32'h44, 32'h1234_5678, 0, 0, 1'b0, 32'd0);
        cpu_access("load_after_store_44", 1'b0, 32'h44, 32'd0, 0, 0, 1'b0, 32'd0);
    endtask

    task automatic test_dirty_miss();
        cpu_access("dirty_miss_240", 1'b0, 32'h240, 32'd0, 0, 3, 1'b1, 32'h40);
        cpu_access("refetch_44", 1'b0, 32'h44, 32'd0, 0, 2, 1'b0, 32'd0);
    endtask

    task automatic test_store_miss();
        cpu_access("store_miss_88", 1'b1, 32'h88, 32'hCAFE_F00D, 0, 2, 1'b0, 32'd0);
        cpu_access("load_88", 1'b0, 32'h88, 32'd0, 0, 0, 1'b0, 32'd0);
        cpu_access("load_8c", 1'b0, 32'h8C, 32'd0, 0, 0, 1'b0, 32'd0);
        cpu_access("evict_80", 1'b0, 32'h288, 32'd0, 0, 3, 1'b1, 32'h80);
    endtask

    task automatic test_back_to_back();
        cpu_access("b2b_st_284", 1'b1, 32'h284, 32'h0BAD_CAFE, 0, 0, 1'b0, 32'd0);
        cpu_access("b2b_ld_284", 1'b0, 32'h284, 32'd0, 0, 0, 1'b0, 32'd0);
        cpu_access("b2b_ld_28c", 1'b0, 32'h28C, 32'd0, 0, 0, 1'b0, 32'd0);
        cpu_access("b2b_st_280", 1'b1, 32'h280, 32'h5555_AAAA, 0, 0, 1'b0, 32'd0);
        cpu_access("b2b_ld_280", 1'b0, 32'h280, 32'd0, 0, 0, 1'b0, 32'd0);
    endtask

    task automatic test_reset_mid_miss();
        @(negedge clk_i);
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h100;
        #1;
        tests++;
        if (cpu_stall_o !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_detect_stall: got %b want 1", cpu_stall_o);
        end
        @(negedge clk_i);
        #1;
        tests++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h100) begin
            fails++;
            $display("FAIL rst_mid_alloc: got req=%b we=%b addr=%h want 1 0 00000100",
                     mem_req_o, mem_we_o, mem_addr_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;
        cpu_words.delete();
        #1;
        tests++;
        if (mem_req_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_drop_req: got req=%b stall=%b want 0 0", mem_req_o, cpu_stall_o);
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = {4{32'hFFFF_FFFF}};
        @(negedge clk_i);
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        #1;
        tests++;
        if (mem_req_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
            fails++;
            $display("FAIL late_ack_ignored: got req=%b stall=%b want 0 0", mem_req_o, cpu_stall_o);
        end
        cpu_access("reload_100", 1'b0, 32'h100, 32'd0, 0, 2, 1'b0, 32'd0);
    endtask

    task automatic test_delayed_ack();
        cpu_access("delayed_ack_300", 1'b0, 32'h300, 32'd0, 10, 12, 1'b0, 32'd0);
        cpu_access("delayed_hit_304", 1'b0, 32'h304, 32'd0, 0, 0, 1'b0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_store_hit();
        test_dirty_miss();
        test_store_miss();
        test_back_to_back();
        test_reset_mid_miss();
        test_delayed_ack();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
